// File: rtl/fb_pkg.sv
// fb_pkg: shared types, constants and helpers for the double-buffered frame store
//   lane_w()   : clog2 of pixels per word (0 when one pixel per word)
//   is_pow2()  : parameter sanity check used by the top
//   bank_t     : bank select
//   DROP_CNT_W : width of the saturating dropped-frame counter
package fb_pkg;
   localparam int DROP_CNT_W = 8;
   typedef logic bank_t;
   function automatic int lane_w(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction
   function automatic bit is_pow2(input int n);
      return n > 0 && (n & (n - 1)) == 0;
   endfunction
endpackage

// File: rtl/fb_sdp_ram.sv
// fb_sdp_ram: simple dual-port single-clock RAM with registered read
//   clk      : clock
//   wr_en    : write strobe, wr_addr/wr_data
//   rd_en    : read strobe, rd_addr; rd_data valid the cycle after rd_en
module fb_sdp_ram #(
   parameter int WIDTH = 32,
   parameter int WORDS = 2,
   parameter int AW    = 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem [WORDS];
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/frame_buffer_dbuf.sv
// frame_buffer_dbuf: double-buffered pixel frame store, packed-word writer, single-pixel reader
//   sys_clk, reset (async active-low)
//   wr_valid/wr_data/wr_frame_end/wr_ready : packed word stream into the back bank
//   rd_frame_start                         : display vblank pulse, swaps banks when a frame is pending
//   rd_req/rd_pix_addr -> rd_valid/rd_pix  : pixel read from the front bank, 2-cycle latency
//   front_bank, frame_pending              : bank status
//   ovf_err, drop_cnt, clr_err             : sticky overflow, dropped-frame count, clear
//   cfg_gain                               : pixel left-shift with saturation, only with FB_GAIN_EN
module frame_buffer_dbuf
   import fb_pkg::*;
#(
   parameter int PIX_W        = 8,
   parameter int PIX_PER_WORD = 4,
   parameter int DEPTH        = 76800,
   parameter int ADDR_W       = 17,
   localparam int WORD_W      = PIX_W * PIX_PER_WORD,
   localparam int LANE_W      = lane_w(PIX_PER_WORD)
) (
   input  logic                     sys_clk,
   input  logic                     reset,
   input  logic                     wr_valid,
   input  logic [WORD_W-1:0]        wr_data,
   input  logic                     wr_frame_end,
   output logic                     wr_ready,
   input  logic                     rd_frame_start,
   input  logic                     rd_req,
   input  logic [ADDR_W+LANE_W-1:0] rd_pix_addr,
   output logic                     rd_valid,
   output logic [PIX_W-1:0]         rd_pix,
   output bank_t                    front_bank,
   output logic                     frame_pending,
   output logic                     ovf_err,
   output logic [DROP_CNT_W-1:0]    drop_cnt,
   input  logic                     clr_err
`ifdef FB_GAIN_EN
   ,
   input  logic [1:0]               cfg_gain
`endif
);
   localparam int RAM_AW = $clog2(2 * DEPTH);
   localparam int LW     = LANE_W > 0 ? LANE_W : 1;
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
   if (!is_pow2(PIX_PER_WORD)) begin : g_bad_ppw
      $error("PIX_PER_WORD must be a power of two");
   end
   if ((2 ** ADDR_W) < DEPTH) begin : g_bad_aw
      $error("ADDR_W too narrow for DEPTH");
   end
   // wr_ptr is one bit wider so it can rest at DEPTH without wrapping
   logic [ADDR_W:0]       wr_ptr;
   logic                  accept, in_range, drop;
   logic [RAM_AW-1:0]     wr_addr, rd_addr;
   logic [ADDR_W-1:0]     rd_word;
   logic [LW-1:0]         rd_lane, s1_lane;
   logic                  rd_oob, s1_valid, s1_oob;
   logic [WORD_W-1:0]     ram_q;
   logic [PIX_W-1:0]      pix, pix_out;
   // pending and ready are always complementary, so ready is derived
   assign wr_ready = ~frame_pending;
   assign accept   = wr_valid & wr_ready;
   assign in_range = wr_ptr < DEPTH_W;
   assign drop     = wr_valid & ~wr_ready & wr_frame_end;
   // bank b occupies RAM words [b*DEPTH, b*DEPTH+DEPTH-1]; back bank is ~front_bank
   assign wr_addr  = RAM_AW'(wr_ptr) + (front_bank ? '0 : RAM_AW'(DEPTH));
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         wr_ptr        <= '0;
         frame_pending <= 1'b0;
         front_bank    <= 1'b0;
         ovf_err       <= 1'b0;
         drop_cnt      <= '0;
      end else begin
         if (accept) wr_ptr <= wr_frame_end ? '0 : wr_ptr + (ADDR_W + 1)'(in_range);
         if (rd_frame_start && frame_pending) begin
            front_bank    <= ~front_bank;
            frame_pending <= 1'b0;
         end else if (accept && wr_frame_end) begin
            frame_pending <= 1'b1;
         end
         if (clr_err) begin
            ovf_err  <= 1'b0;
            drop_cnt <= '0;
         end else begin
            if (accept && !in_range) ovf_err <= 1'b1;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
         end
      end
   end
   assign rd_word = rd_pix_addr[ADDR_W+LANE_W-1:LANE_W];
   if (LANE_W > 0) begin : g_lane
      assign rd_lane = rd_pix_addr[LW-1:0];
   end else begin : g_nolane
      assign rd_lane = '0;
   end
   assign rd_oob  = {1'b0, rd_word} >= DEPTH_W;
   // bank is taken from front_bank at request time, so a later swap cannot disturb this read
   assign rd_addr = RAM_AW'(rd_word) + (front_bank ? RAM_AW'(DEPTH) : '0);
   fb_sdp_ram #(.WIDTH(WORD_W), .WORDS(2 * DEPTH), .AW(RAM_AW)) u_ram (
      .clk     (sys_clk),
      .wr_en   (accept & in_range),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_req & ~rd_oob),
      .rd_addr (rd_addr),
      .rd_data (ram_q)
   );
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_oob   <= 1'b0;
         s1_lane  <= '0;
      end else begin
         s1_valid <= rd_req;
         s1_oob   <= rd_oob;
         s1_lane  <= rd_lane;
      end
   end
   assign pix = ram_q[s1_lane*PIX_W +: PIX_W];
`ifdef FB_GAIN_EN
   logic [PIX_W+2:0] shifted;
   assign shifted = {3'b000, pix} << cfg_gain;
   assign pix_out = |shifted[PIX_W+2:PIX_W] ? '1 : shifted[PIX_W-1:0];
`else
   assign pix_out = pix;
`endif
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         rd_valid <= 1'b0;
         rd_pix   <= '0;
      end else begin
         rd_valid <= s1_valid;
         if (s1_valid) rd_pix <= s1_oob ? '0 : pix_out;
      end
   end
endmodule

// File: tb/tb_frame_buffer_dbuf.sv
// tb_frame_buffer_dbuf: self-checking bench for frame_buffer_dbuf (DEPTH=12, 4 pixels/word)
module tb_frame_buffer_dbuf;
   localparam int PIX_W = 8, PPW = 4, DEPTH = 12, ADDR_W = 4, LANE_W = 2;
   localparam int WORD_W = PIX_W * PPW, PA_W = ADDR_W + LANE_W;
   logic sys_clk = 0, reset = 0, wr_valid = 0, wr_frame_end = 0;
   logic rd_frame_start = 0, rd_req = 0, clr_err = 0;
   logic [WORD_W-1:0] wr_data = '0;
   logic [PA_W-1:0] rd_pix_addr = '0;
   logic wr_ready, rd_valid, front_bank, frame_pending, ovf_err;
   logic [PIX_W-1:0] rd_pix;
   logic [7:0] drop_cnt;
`ifdef FB_GAIN_EN
   logic [1:0] cfg_gain = 2'd0;
`endif
   always #5 sys_clk = ~sys_clk;
   frame_buffer_dbuf #(.PIX_W(PIX_W), .PIX_PER_WORD(PPW), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .sys_clk(sys_clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_frame_end(wr_frame_end), .wr_ready(wr_ready), .rd_frame_start(rd_frame_start),
      .rd_req(rd_req), .rd_pix_addr(rd_pix_addr), .rd_valid(rd_valid), .rd_pix(rd_pix),
      .front_bank(front_bank), .frame_pending(frame_pending), .ovf_err(ovf_err),
      .drop_cnt(drop_cnt), .clr_err(clr_err)
`ifdef FB_GAIN_EN
      , .cfg_gain(cfg_gain)
`endif
   );
   int checks = 0, errors = 0;
   // reference model: two banks of words, plus the frame bookkeeping rules
   logic [WORD_W-1:0] m_mem [2][DEPTH];
   bit m_known [2][DEPTH];
   int m_ptr, m_drop;
   bit m_front, m_pend, m_ovf;
   bit lat_v, lat_k, e_v, e_k;
   logic [PIX_W-1:0] lat_p, e_p;
   typedef struct {
      logic [PA_W-1:0]  addr;
      logic [PIX_W-1:0] exp;
   } vec_t;
   vec_t tbl [36];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [PIX_W-1:0] gain(input logic [PIX_W-1:0] p);
`ifdef FB_GAIN_EN
      int v;
      v = int'(p) * (1 << cfg_gain);
      return v > 255 ? 8'hFF : 8'(v);
`else
      return p;
`endif
   endfunction
   task automatic model_reset();
      m_ptr = 0; m_drop = 0; m_front = 0; m_pend = 0; m_ovf = 0;
      lat_v = 0; lat_k = 0; lat_p = '0; e_v = 0; e_k = 1; e_p = '0;
      foreach (m_known[b, w]) m_known[b][w] = 0;
   endtask
   task automatic model_edge();
      bit pend0;
      int w, l;
      pend0 = m_pend;
      if (!reset) begin
         model_reset();
         return;
      end
      e_v = lat_v;
      if (lat_v) begin e_p = lat_p; e_k = lat_k; end
      lat_v = rd_req;
      if (rd_req) begin
         w = int'(rd_pix_addr) / PPW;
         l = int'(rd_pix_addr) % PPW;
         if (w >= DEPTH) begin
            lat_p = '0; lat_k = 1;
         end else begin
            lat_k = m_known[m_front][w];
            lat_p = gain(PIX_W'(m_mem[m_front][w] >> (l * PIX_W)));
         end
      end
      if (wr_valid && !pend0) begin
         if (m_ptr < DEPTH) begin
            m_mem[!m_front][m_ptr] = wr_data;
            m_known[!m_front][m_ptr] = 1;
            m_ptr++;
         end else m_ovf = 1;
         if (wr_frame_end) begin m_ptr = 0; m_pend = 1; end
      end else if (wr_valid && wr_frame_end) m_drop = m_drop < 255 ? m_drop + 1 : 255;
      if (rd_frame_start && pend0) begin m_front = !m_front; m_pend = 0; end
      if (clr_err) begin m_ovf = 0; m_drop = 0; end
   endtask
   task automatic compare_all();
      chk("wr_ready", wr_ready, !m_pend);
      chk("front_bank", front_bank, m_front);
      chk("frame_pending", frame_pending, m_pend);
      chk("ovf_err", ovf_err, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("rd_valid", rd_valid, e_v);
      if (e_k) chk("rd_pix", rd_pix, e_p);
   endtask
   task automatic cyc();
      @(posedge sys_clk);
      model_edge();
      @(negedge sys_clk);
      compare_all();
   endtask
   task automatic reset_vals(input string tag);
      chk({tag, "_wr_ready"}, wr_ready, 1);
      chk({tag, "_rd_valid"}, rd_valid, 0);
      chk({tag, "_rd_pix"}, rd_pix, 0);
      chk({tag, "_front"}, front_bank, 0);
      chk({tag, "_pending"}, frame_pending, 0);
      chk({tag, "_ovf"}, ovf_err, 0);
      chk({tag, "_drop"}, drop_cnt, 0);
   endtask
   task automatic wr_word(input logic [WORD_W-1:0] d, input bit fe);
      wr_valid = 1; wr_data = d; wr_frame_end = fe;
      cyc();
      wr_valid = 0; wr_frame_end = 0;
   endtask
   task automatic swap();
      rd_frame_start = 1;
      cyc();
      rd_frame_start = 0;
   endtask
   initial begin
      for (int a = 0; a < 32; a++) tbl[a] = '{PA_W'((a * 7) % 32), PIX_W'((a * 7) % 32)};
      for (int a = 32; a < 36; a++) tbl[a] = '{PA_W'(16 + a), 8'h00};
      model_reset();
      cyc();
      cyc();
      reset_vals("reset");
      reset = 1;
      cyc();
      // frame A: pixel n holds value n
      for (int i = 0; i < 8; i++) wr_word(32'h03020100 + 32'h04040404 * i, i == 7);
      chk("t1_pending", frame_pending, 1);
      swap();
      chk("t1_front", front_bank, 1);
      for (int i = 0; i <= 36; i++) begin
         rd_req = i < 36;
         if (i < 36) rd_pix_addr = tbl[i].addr;
         cyc();
         if (i >= 1) begin
            chk("t1_valid", rd_valid, 1);
            chk("t1_pix", rd_pix, tbl[i-1].exp);
         end
      end
      rd_req = 0;
      cyc();
      chk("t1_valid_off", rd_valid, 0);
      // frame B completes, frame C arrives before any swap and is dropped
      for (int i = 0; i < 3; i++) wr_word(32'hB0B0B0B0 + i, i == 2);
      chk("t2_ready", wr_ready, 0);
      for (int i = 0; i < 3; i++) wr_word(32'hC0C0C0C0 + i, i == 2);
      chk("t2_drop", drop_cnt, 1);
      for (int i = 0; i <= 8; i++) begin
         rd_req = i < 8;
         rd_pix_addr = PA_W'(i);
         cyc();
         if (i >= 1) chk("t2_front_data", rd_pix, i - 1);
      end
      rd_req = 0;
      swap();
      // overflow: 14 words into a 12-word bank
      for (int i = 0; i < 14; i++) wr_word(32'hA0A0A000 + i, 0);
      chk("t3_ovf", ovf_err, 1);
      chk("t3_ready", wr_ready, 1);
      clr_err = 1;
      cyc();
      clr_err = 0;
      chk("t3_ovf_clr", ovf_err, 0);
      chk("t3_drop_clr", drop_cnt, 0);
      wr_word(32'hDEADBEEF, 1);
      swap();
      for (int i = 0; i <= 8; i++) begin
         rd_req = i < 8;
         rd_pix_addr = PA_W'(44 + i);
         cyc();
         if (i >= 1) chk("t3_rd_valid", rd_valid, 1);
      end
      rd_req = 0;
      // burst reads with a swap in the middle
      for (int i = 0; i < 4; i++) wr_word(32'h10203040 * (i + 1), i == 3);
      for (int i = 0; i < 16; i++) begin
         rd_req = 1;
         rd_pix_addr = PA_W'($urandom_range(0, 15));
         rd_frame_start = i == 6;
         cyc();
         if (i >= 1) chk("t4_valid", rd_valid, 1);
      end
      rd_req = 0; rd_frame_start = 0;
      cyc();
      chk("t4_front", front_bank, 0);
`ifdef FB_GAIN_EN
      cfg_gain = 2;
      wr_word(32'h00005030, 1);
      swap();
      rd_req = 1; rd_pix_addr = 0;
      cyc();
      rd_pix_addr = 1;
      cyc();
      chk("t5_gain", rd_pix, 8'hC0);
      rd_req = 0;
      cyc();
      chk("t5_sat", rd_pix, 8'hFF);
      cyc();
`endif
      // reset during a write burst and a read burst
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1; wr_data = $urandom; rd_req = 1; rd_pix_addr = PA_W'(i);
         cyc();
      end
      reset = 0;
      #1;
      reset_vals("t6_async");
      cyc();
      reset_vals("t6_held");
      reset = 1; wr_valid = 0; rd_req = 0;
      cyc();
      for (int i = 0; i < 1500; i++) begin
         wr_valid = ($urandom % 3) != 0;
         wr_data = $urandom;
         wr_frame_end = ($urandom % 12) == 0;
         rd_frame_start = ($urandom % 10) == 0;
         rd_req = $urandom % 2;
         rd_pix_addr = PA_W'($urandom);
         clr_err = ($urandom % 60) == 0;
         reset = ($urandom % 400) != 0;
         cyc();
      end
      reset = 1; wr_valid = 0; wr_frame_end = 0; rd_frame_start = 0; rd_req = 0; clr_err = 0;
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
